mpadd_seq: RTL and testbench

MPADD_SEQ -- requirements
Module: mpadd_seq

---
 rtl/mpadd_if.sv | 26 ++
 rtl/mpadd_seq.sv | 131 +++++++++++++
 tb/tb_mpadd_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mpadd_if.sv
// Handshake and operand bus for the sequential multi-word adder mpadd_seq.
interface mpadd_if #(parameter int LENW = 3);
    logic            start;
    logic [LENW-1:0] len;
    logic            cin;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     a;
    logic [15:0]     b;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     sum;
    logic            last;
    logic            cout;
    logic            busy;

    modport master (
        output start, len, cin, in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, last, cout, busy
    );

    modport slave (
        input  start, len, cin, in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, last, cout, busy
    );
endinterface

// File: rtl/mpadd_seq.sv
// Word-serial multi-precision adder: one 16-bit word per cycle, carry kept between words.
// Optional macro MPADD_SUBTRACT_EN adds a sub port selecting A + ~B + 1 per transaction.

// 16-bit carry-lookahead adder; g_out/p_out are the group generate/propagate
// so the caller can form the carry-out from its own registered carry.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        g_out,
    output logic        p_out
);
    logic [15:0] g, p, cc;
    logic [3:0]  gg, gp, nc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        cc = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        nc[0] = ci;
        nc[1] = gg[0] | (gp[0] & ci);
        nc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        nc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
        for (int k = 0; k < 4; k++) begin
            cc[4*k] = nc[k];
            for (int j = 0; j < 3; j++)
                cc[4*k+j+1] = g[4*k+j] | (p[4*k+j] & cc[4*k+j]);
        end
        s     = p ^ cc;
        g_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        p_out = &gp;
    end
endmodule

// state | meaning
// IDLE  | waiting for start; no input accepted
// RUN   | accepting A/B words into the one-entry output register
// DRAIN | final word registered; waiting for it to be taken
module mpadd_seq #(parameter int LENW = 3) (
    input  logic   clk,
    input  logic   rst,
`ifdef MPADD_SUBTRACT_EN
    input  logic   sub,
`endif
    mpadd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic            c;
    logic [LENW-1:0] count, len_q;
    logic [15:0]     b_op, s_word;
    logic            g_word, p_word, carry_out;
    logic            accept, is_last, take;

`ifdef MPADD_SUBTRACT_EN
    logic sub_q;
    assign b_op = sub_q ? ~bus.b : bus.b;
`else
    assign b_op = bus.b;
`endif

    cla16 u_cla (.a(bus.a), .b(b_op), .ci(c), .s(s_word), .g_out(g_word), .p_out(p_word));

    assign carry_out    = g_word | (p_word & c);
    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign bus.busy     = (state != IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_last      = (count == len_q);
    assign take         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)        state_nxt = RUN;
            RUN:     if (accept && is_last) state_nxt = DRAIN;
            DRAIN:   if (take)             state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c             <= 1'b0;
            count         <= '0;
            len_q         <= '0;
            bus.sum       <= '0;
            bus.out_valid <= 1'b0;
            bus.last      <= 1'b0;
            bus.cout      <= 1'b0;
`ifdef MPADD_SUBTRACT_EN
            sub_q         <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.start) begin
                len_q <= bus.len;
                count <= '0;
`ifdef MPADD_SUBTRACT_EN
                sub_q <= sub;
                c     <= sub ? 1'b1 : bus.cin;
`else
                c     <= bus.cin;
`endif
            end
            // Accept and output handshake together simply overwrite the word.
            if (accept) begin
                bus.sum       <= s_word;
                c             <= carry_out;
                bus.cout      <= carry_out;
                bus.out_valid <= 1'b1;
                bus.last      <= is_last;
                count         <= count + 1'b1;
            end else if (take) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq; build with MPADD_SUBTRACT_EN to also cover subtraction.
module tb_mpadd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] av[8], bv[8], ev[8];

    always #5 clk = ~clk;

    mpadd_if #(.LENW(3)) bus ();

`ifdef MPADD_SUBTRACT_EN
    logic sub = 1'b0;
    mpadd_seq #(.LENW(3)) dut (.clk(clk), .rst(rst), .sub(sub), .bus(bus));
`else
    mpadd_seq #(.LENW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from av/bv, expecting ev and exp_co; out_ready is
    // held low for `stall` cycles once the first word is presented.
    task automatic run_txn(input int ln, input bit ci, input bit exp_co, input int stall, input bit poke);
        int  widx, oidx, stall_left, t, first_acc, prev_out;
        bit  seen;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 0);
        bus.start = 1'b1;
        bus.len   = ln[2:0];
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_run", bus.busy, 1);
        widx = 0; oidx = 0; stall_left = stall; t = 0; first_acc = 0; prev_out = 0; seen = 0;
        while (oidx <= ln && t < 100) begin
            bus.start = poke && (widx == 1);
            bus.len   = (poke && widx == 1) ? 3'd0 : ln[2:0];
            if (bus.out_valid) begin
                chk("sum", bus.sum, ev[oidx]);
                chk("last", bus.last, oidx == ln);
                if (oidx == ln) chk("cout", bus.cout, exp_co);
                if (!seen) begin
                    chk("latency", t - first_acc, 1);
                    seen = 1;
                end
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                    if (oidx > 0 && stall == 0) chk("gap", t - prev_out, 1);
                    prev_out = t;
                    oidx++;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            bus.in_valid = (widx <= ln);
            bus.a = av[widx & 7];
            bus.b = bv[widx & 7];
            #1;
            if (!bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) begin
                if (widx == 0) first_acc = t;
                widx++;
            end
            t++;
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (t >= 100) chk("timeout_words", oidx, ln + 1);
        chk("busy_done", bus.busy, 0);
        chk("valid_done", bus.out_valid, 0);
    endtask

    initial begin
        bus.start = 0; bus.len = 0; bus.cin = 0; bus.in_valid = 0;
        bus.a = 0; bus.b = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_last", bus.last, 0);
        chk("rst_cout", bus.cout, 0);
        rst = 1'b0;

        // Single word: FFFF + 0001 carries out
        av = '{16'hFFFF, 0, 0, 0, 0, 0, 0, 0};
        bv = '{16'h0001, 0, 0, 0, 0, 0, 0, 0};
        ev = '{16'h0000, 0, 0, 0, 0, 0, 0, 0};
        run_txn(0, 0, 1, 0, 0);

        // Carry ripples through four words at full rate
        av = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0};
        bv = '{16'h0001, 0, 0, 0, 0, 0, 0, 0};
        ev = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_txn(3, 0, 1, 0, 0);

        // Output stalled three cycles; cin=1 enters word 0 only
        av = '{16'h1234, 16'h0001, 0, 0, 0, 0, 0, 0};
        bv = '{16'h1111, 16'h0002, 0, 0, 0, 0, 0, 0};
        ev = '{16'h2346, 16'h0003, 0, 0, 0, 0, 0, 0};
        run_txn(1, 1, 0, 3, 0);

        // Maximum length; count wraps after the eighth word
        av = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        bv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        ev = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        run_txn(7, 0, 1, 0, 0);

        // Start pulsed (with len=0) mid-run must not restart the transaction
        av = '{16'h0005, 16'h0006, 16'h0007, 0, 0, 0, 0, 0};
        bv = '{16'h0003, 16'h0004, 16'h0005, 0, 0, 0, 0, 0};
        ev = '{16'h0008, 16'h000A, 16'h000C, 0, 0, 0, 0, 0};
        run_txn(2, 0, 0, 0, 1);

        // Reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1; bus.len = 3'd3; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_sum", bus.sum, 16'h0002);
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.out_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        bus.in_valid = 1'b0;

        // Carry-in plus saturated words after reset
        av = '{16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0};
        bv = '{16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0};
        ev = '{16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0};
        run_txn(1, 1, 0, 0, 0);

`ifdef MPADD_SUBTRACT_EN
        // 0001_0000 - 0000_0001 = 0000_FFFF, no borrow
        sub = 1'b1;
        av = '{16'h0000, 16'h0001, 0, 0, 0, 0, 0, 0};
        bv = '{16'h0001, 16'h0000, 0, 0, 0, 0, 0, 0};
        ev = '{16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0};
        run_txn(1, 0, 1, 0, 0);
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
